// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. Each requester has a valid/ready request channel and a
// valid/ready response channel. The block drives the ALU bus from the winner
// and captures the ALU output into a single registered response that is held
// until the owning requester consumes it.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [2*OPW-1:0]     req_op,
    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [WIDTH-1:0]     resp_result,
    output logic                 resp_branch,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [OPW-1:0]       alu_op,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_branch
);

    localparam logic [OPW-1:0] OP_ADD = '0;
    localparam logic [OPW-1:0] OP_BLT = OPW'(5);
    localparam logic [OPW-1:0] OP_BGT = OPW'(9);
    localparam logic [OPW-1:0] OP_BEQ = OPW'(12);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    // Index of the most recent winner; while in RESP it also names the
    // requester that owns the held response.
    logic               last_grant_q, last_grant_d;
    logic [1:0]         resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]   resp_result_q, resp_result_d;
    logic               resp_branch_q, resp_branch_d;

    logic               grant_valid;
    logic               grant_idx;
    logic               is_branch;

    logic [WIDTH-1:0]   a_arr  [2];
    logic [WIDTH-1:0]   b_arr  [2];
    logic [OPW-1:0]     op_arr [2];

    // Unpack the flattened per-requester request fields.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
            assign op_arr[gi] = req_op[gi*OPW +: OPW];
        end
    endgenerate

    // Round-robin grant, only evaluated while idle; a tie goes to the
    // requester that did not win last time.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_idx   = 1'b0;
                end
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_idx   = 1'b1;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    grant_idx   = ~last_grant_q;
                end
                default: begin
                    grant_valid = 1'b0;
                    grant_idx   = 1'b0;
                end
            endcase
        end
    end

    // Drive the ALU bus from the winner, or a quiet ADD 0,0 with no grant.
    always_comb begin
        req_ready = 2'b00;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = OP_ADD;
        if (grant_valid) begin
            req_ready = 2'b01 << grant_idx;
            alu_a     = a_arr[grant_idx];
            alu_b     = b_arr[grant_idx];
            alu_op    = op_arr[grant_idx];
        end
    end

    assign is_branch = (alu_op == OP_BEQ) || (alu_op == OP_BGT) || (alu_op == OP_BLT);

    // Next-state logic: capture on accept, release on consumption by the owner.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_branch_d = resp_branch_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d      = RESP;
                    last_grant_d = grant_idx;
                    resp_valid_d = 2'b01 << grant_idx;
                    // Mask whichever ALU output is meaningless for this op.
                    if (is_branch) begin
                        resp_result_d = '0;
                        resp_branch_d = alu_branch;
                    end else begin
                        resp_result_d = alu_result;
                        resp_branch_d = 1'b0;
                    end
                end
            end
            RESP: begin
                if (resp_ready[last_grant_q]) begin
                    state_d      = IDLE;
                    resp_valid_d = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            resp_valid_q  <= 2'b00;
            resp_result_q <= '0;
            resp_branch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_branch_q <= resp_branch_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_branch = resp_branch_q;

endmodule
